// File: rtl/repetition_rx_assembler_if.sv
// -----------------------------------------------------------------------------
// repetition_rx_assembler_if
//
// Purpose: groups the serial-bit input, the codeword hand-off and the status
// signals of repetition_rx_assembler into one bundle.
//
// Signals:
//   frame_start  - resync; next accepted bit becomes codeword bit 0
//   bit_in       - serial channel bit
//   bit_valid    - bit_in qualifier
//   codeword_out - assembled codeword (CW bits, first received bit = LSB)
//   decode_en    - codeword_out valid
//   decode_ready - consumer accepts codeword_out this cycle
//   bit_count    - bits collected in the current frame
//   overrun      - one-cycle pulse: bit dropped while the assembler stalled
//   timeout      - one-cycle pulse: partial frame discarded on an idle gap
//
// Modports:
//   master - the assembler (drives codeword/status, receives bits/ready)
//   slave  - the environment (drives bits/ready, receives codeword/status)
// -----------------------------------------------------------------------------
interface repetition_rx_assembler_if #(
   parameter int DATA_WIDTH        = 8,
   parameter int REPETITION_FACTOR = 3
);
   localparam int CW    = DATA_WIDTH * REPETITION_FACTOR;
   localparam int CNT_W = $clog2(CW + 1);

   logic             frame_start;
   logic             bit_in;
   logic             bit_valid;
   logic [CW-1:0]    codeword_out;
   logic             decode_en;
   logic             decode_ready;
   logic [CNT_W-1:0] bit_count;
   logic             overrun;
   logic             timeout;

   modport master (
      input  frame_start,
      input  bit_in,
      input  bit_valid,
      input  decode_ready,
      output codeword_out,
      output decode_en,
      output bit_count,
      output overrun,
      output timeout
   );

   modport slave (
      output frame_start,
      output bit_in,
      output bit_valid,
      output decode_ready,
      input  codeword_out,
      input  decode_en,
      input  bit_count,
      input  overrun,
      input  timeout
   );
endinterface

// File: rtl/repetition_rx_assembler.sv
// -----------------------------------------------------------------------------
// repetition_rx_assembler
//
// Purpose: collects serial channel bits into a CW = DATA_WIDTH *
// REPETITION_FACTOR bit codeword for a repetition decoder. The k-th accepted
// bit of a frame lands at codeword bit k. A completed frame is handed to a
// single-entry output buffer (valid flag = decode_en); if the buffer is still
// occupied the frame is parked (STALL) until the buffer drains, and bits
// arriving meanwhile are dropped with an overrun pulse.
//
// Ports:
//   clk   - clock, all logic on the rising edge
//   rst_n - synchronous active-low reset, highest priority
//   bus   - repetition_rx_assembler_if.master (frame_start, bit_in,
//           bit_valid, decode_ready in; codeword_out, decode_en, bit_count,
//           overrun, timeout out)
//
// Build option:
//   REP_RX_TIMEOUT_EN - when defined, a partial frame that sees TIMEOUT_CYCLES
//                       consecutive cycles without bit_valid is discarded and
//                       timeout pulses. When undefined there is no counter,
//                       timeout is tied low and partial frames wait forever.
// -----------------------------------------------------------------------------
module repetition_rx_assembler #(
   parameter int DATA_WIDTH        = 8,
   parameter int REPETITION_FACTOR = 3,
   parameter int TIMEOUT_CYCLES    = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   repetition_rx_assembler_if.master bus
);
   localparam int CW    = DATA_WIDTH * REPETITION_FACTOR;
   localparam int CNT_W = $clog2(CW + 1);
   localparam logic [CNT_W-1:0] CW_COUNT = CNT_W'(CW);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_STALL   = 2'd2;

   generate
      if (DATA_WIDTH < 1 || REPETITION_FACTOR < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
         $error("repetition_rx_assembler: DATA_WIDTH, REPETITION_FACTOR and TIMEOUT_CYCLES must be >= 1");
      end
   endgenerate

   logic [1:0]       state_reg,     state_next;
   logic [CNT_W-1:0] bit_count_reg, bit_count_next;
   logic [CW-1:0]    frame_reg,     frame_next;
   logic [CW-1:0]    codeword_reg,  codeword_next;
   logic             decode_en_reg, decode_en_next;
   logic             overrun_reg,   overrun_next;

   logic             drain;
   logic             accept;
   logic [CNT_W-1:0] wr_idx;
   logic [CNT_W-1:0] count_inc;
   logic             tmo_fire;

   // The output buffer empties whenever the consumer takes a valid codeword.
   assign drain = decode_en_reg & bus.decode_ready;

   // A bit is stored unless a finished frame is parked; frame_start reopens
   // collection in the same cycle, so it overrides the STALL drop.
   assign accept    = bus.bit_valid & (bus.frame_start | (state_reg != ST_STALL));
   assign wr_idx    = bus.frame_start ? '0 : bit_count_reg;
   assign count_inc = wr_idx + CNT_W'(1);

   // Per-bit write of the assembly register: only the addressed bit changes.
   genvar gi;
   generate
      for (gi = 0; gi < CW; gi++) begin : g_frame_bit
         assign frame_next[gi] = (accept && (wr_idx == CNT_W'(gi))) ? bus.bit_in
                                                                     : frame_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      bit_count_next = bit_count_reg;
      codeword_next  = codeword_reg;
      decode_en_next = decode_en_reg & ~drain;
      overrun_next   = 1'b0;

      if (accept) begin
         if (count_inc == CW_COUNT) begin
            // Frame complete: hand it over now if the buffer is (or is
            // becoming) free, otherwise park it.
            if (!decode_en_reg || drain) begin
               codeword_next  = frame_next;
               decode_en_next = 1'b1;
               bit_count_next = '0;
               state_next     = ST_IDLE;
            end else begin
               bit_count_next = CW_COUNT;
               state_next     = ST_STALL;
            end
         end else begin
            bit_count_next = count_inc;
            state_next     = ST_COLLECT;
         end
      end else if (bus.frame_start) begin
         bit_count_next = '0;
         state_next     = ST_IDLE;
      end else if (state_reg == ST_STALL) begin
         overrun_next = bus.bit_valid;
         if (drain) begin
            codeword_next  = frame_reg;
            decode_en_next = 1'b1;
            bit_count_next = '0;
            state_next     = ST_IDLE;
         end
      end else if (tmo_fire) begin
         bit_count_next = '0;
         state_next     = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         bit_count_reg <= '0;
         frame_reg     <= '0;
         codeword_reg  <= '0;
         decode_en_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_count_reg <= bit_count_next;
         frame_reg     <= frame_next;
         codeword_reg  <= codeword_next;
         decode_en_reg <= decode_en_next;
         overrun_reg   <= overrun_next;
      end
   end

`ifdef REP_RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             timeout_reg;
   logic             idle_gap;

   // Only a partially filled frame can time out; IDLE and STALL never do.
   assign idle_gap = (state_reg == ST_COLLECT) & ~bus.bit_valid & ~bus.frame_start;
   assign tmo_fire = idle_gap & (tmo_cnt_reg == TMO_LAST);

   always_comb begin
      tmo_cnt_next = '0;
      if (idle_gap && !tmo_fire) begin
         tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_reg <= '0;
         timeout_reg <= 1'b0;
      end else begin
         tmo_cnt_reg <= tmo_cnt_next;
         timeout_reg <= tmo_fire;
      end
   end

   assign bus.timeout = timeout_reg;
`else
   assign tmo_fire    = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.codeword_out = codeword_reg;
   assign bus.decode_en    = decode_en_reg;
   assign bus.bit_count    = bit_count_reg;
   assign bus.overrun      = overrun_reg;
endmodule
